// File: rtl/jtframe_osd_seq.sv
// OSD host-port command sequencer.
// Turns a single-cycle request into a framed, strobe-paced word sequence on
// io_osd/io_strobe/io_din. Ops: 0 disable, 1 menu enable, 2 info box with geometry,
// 3 bitmap write streamed from a local byte memory (one-cycle read latency).
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   req_i, op_i                request and opcode (sampled only while idle)
//   info_*_i                   info box geometry/rotation (op 2)
//   wr_blk_i, wr_len_i         destination block and byte count (op 3)
//   rd_addr_o, rd_en_o, rd_data_i  source memory read port
//   busy_o, done_o             sequence in progress / one-cycle end pulse
//   io_osd_o, io_strobe_o, io_din_o  OSD host interface
module jtframe_osd_seq #(
  parameter int unsigned STRW = 2,
  parameter int unsigned GAPW = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [1:0]  op_i,
  input  logic [11:0] info_x_i,
  input  logic [11:0] info_y_i,
  input  logic [5:0]  info_w_i,
  input  logic [5:0]  info_h_i,
  input  logic [1:0]  info_rot_i,
  input  logic [4:0]  wr_blk_i,
  input  logic [12:0] wr_len_i,
  output logic [12:0] rd_addr_o,
  output logic        rd_en_o,
  input  logic [7:0]  rd_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        io_osd_o,
  output logic        io_strobe_o,
  output logic [15:0] io_din_o
);

  localparam int unsigned MaxW = (STRW > GAPW) ? STRW : GAPW;
  localparam int unsigned CntW = $clog2(MaxW + 1);

  typedef enum logic [2:0] {StIdle, StLead, StHi, StLo, StTail} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [13:0]      rem_q, rem_d;     // words still to send after the current one
  logic [1:0]       op_q, op_d;
  logic [4:0][11:0] sh_q, sh_d;       // pending op-2 operand words, [0] goes next
  logic [15:0]      din_q, din_d;
  logic [12:0]      addr_q, addr_d;
  logic             fetch_q, fetch_d; // rd_data_i holds the next data byte this cycle
  logic             done_q, done_d;
  logic             rd_en;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sh_q    <= '0;
      din_q   <= '0;
      addr_q  <= '0;
      fetch_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rem_d   = rem_q;
    op_d    = op_q;
    sh_d    = sh_q;
    din_d   = din_q;
    addr_d  = addr_q;
    fetch_d = 1'b0;
    done_d  = 1'b0;
    rd_en   = 1'b0;

    // Byte fetched last cycle lands in io_din ahead of the HI phase.
    if (fetch_q) din_d = {8'h00, rd_data_i};

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        din_d  = '0;
        addr_d = '0;
        if (req_i) begin
          state_d = StLead;
          op_d    = op_i;
          sh_d    = {{10'b0, info_rot_i}, {6'b0, info_h_i}, {6'b0, info_w_i}, info_y_i, info_x_i};
          unique case (op_i)
            2'd0: begin din_d = 16'h0040; rem_d = 14'd0; end
            2'd1: begin din_d = 16'h0041; rem_d = 14'd0; end
            2'd2: begin din_d = 16'h0045; rem_d = 14'd5; end
            2'd3: begin din_d = {11'h001, wr_blk_i}; rem_d = {1'b0, wr_len_i}; end
            default: ;
          endcase
        end
      end
      StLead: begin
        if (cnt_q == CntW'(GAPW - 1)) begin
          state_d = StHi;
          cnt_d   = '0;
        end
      end
      StHi: begin
        if (cnt_q == CntW'(STRW - 1)) begin
          state_d = StLo;
          cnt_d   = '0;
          if (op_q == 2'd2 && rem_q != '0) begin
            din_d = {4'b0, sh_q[0]};
            sh_d  = {12'b0, sh_q[4:1]};
          end
        end
      end
      StLo: begin
        if (cnt_q == '0 && op_q == 2'd3 && rem_q != '0) begin
          rd_en   = 1'b1;
          fetch_d = 1'b1;
          // Hold on the final byte so rd_addr stays within 0..wr_len-1.
          if (rem_q != 14'd1) addr_d = addr_q + 1'b1;
        end
        if (cnt_q == CntW'(GAPW - 1)) begin
          cnt_d = '0;
          if (rem_q == '0) begin
            state_d = StTail;
          end else begin
            state_d = StHi;
            rem_d   = rem_q - 1'b1;
          end
        end
      end
      StTail: begin
        if (cnt_q == CntW'(GAPW - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
          din_d   = '0;
          addr_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr_o   = addr_q;
  assign rd_en_o     = rd_en;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign io_osd_o    = (state_q == StLead) || (state_q == StHi) || (state_q == StLo);
  assign io_strobe_o = (state_q == StHi);
  assign io_din_o    = din_q;

endmodule

// File: tb/tb_jtframe_osd_seq.sv
module tb_jtframe_osd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic [7:0] mem [0:8191];

  // DUT A: STRW=2 GAPW=2
  logic        a_req = 1'b0;
  logic [1:0]  a_op = '0, a_rot = '0;
  logic [11:0] a_x = '0, a_y = '0;
  logic [5:0]  a_w = '0, a_h = '0;
  logic [4:0]  a_blk = '0;
  logic [12:0] a_len = '0;
  logic [12:0] a_rd_addr;
  logic        a_rd_en, a_busy, a_done, a_osd, a_strobe;
  logic [7:0]  a_rd_data = '0;
  logic [15:0] a_din;

  jtframe_osd_seq #(.STRW(2), .GAPW(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .op_i(a_op),
    .info_x_i(a_x), .info_y_i(a_y), .info_w_i(a_w), .info_h_i(a_h), .info_rot_i(a_rot),
    .wr_blk_i(a_blk), .wr_len_i(a_len), .rd_addr_o(a_rd_addr), .rd_en_o(a_rd_en),
    .rd_data_i(a_rd_data), .busy_o(a_busy), .done_o(a_done), .io_osd_o(a_osd),
    .io_strobe_o(a_strobe), .io_din_o(a_din)
  );

  // DUT B: STRW=1 GAPW=3
  logic        b_req = 1'b0;
  logic [1:0]  b_op = '0;
  logic [4:0]  b_blk = '0;
  logic [12:0] b_len = '0;
  logic [12:0] b_rd_addr;
  logic        b_rd_en, b_busy, b_done, b_osd, b_strobe;
  logic [7:0]  b_rd_data = '0;
  logic [15:0] b_din;

  jtframe_osd_seq #(.STRW(1), .GAPW(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .op_i(b_op),
    .info_x_i(12'd0), .info_y_i(12'd0), .info_w_i(6'd0), .info_h_i(6'd0), .info_rot_i(2'd0),
    .wr_blk_i(b_blk), .wr_len_i(b_len), .rd_addr_o(b_rd_addr), .rd_en_o(b_rd_en),
    .rd_data_i(b_rd_data), .busy_o(b_busy), .done_o(b_done), .io_osd_o(b_osd),
    .io_strobe_o(b_strobe), .io_din_o(b_din)
  );

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem[b_rd_addr];
  end

  // Scoreboard queues for DUT A
  logic [15:0] exp_word [$];
  logic [12:0] exp_addr [$];
  int          exp_busy [$];
  int          exp_osd  [$];
  int          exp_done_a = 0;
  // Scoreboard queues for DUT B
  logic [15:0] expb_word [$];
  int          expb_busy [$];
  int          expb_osd  [$];

  // Monitor A
  int a_rise = 0, a_done_cnt = 0;
  int a_busy_cnt = 0, a_osd_cnt = 0, a_hi_cnt = 0;
  logic a_pstb = 1'b0, a_pbusy = 1'b0, a_posd = 1'b0;
  logic [15:0] a_hi_word = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_pstb = 1'b0; a_pbusy = 1'b0; a_posd = 1'b0;
      a_busy_cnt = 0; a_osd_cnt = 0; a_hi_cnt = 0;
    end else begin
      if (a_strobe && !a_pstb) begin
        a_rise++;
        if (exp_word.size() == 0) chk("a_word_extra", {16'h0, a_din}, 32'hffff_ffff);
        else chk("a_word", {16'h0, a_din}, {16'h0, exp_word.pop_front()});
        a_hi_word = a_din;
        a_hi_cnt = 0;
      end
      if (a_strobe) begin
        if (a_pstb) chk("a_din_stable_hi", {16'h0, a_din}, {16'h0, a_hi_word});
        a_hi_cnt++;
      end else if (a_pstb) chk("a_strobe_len", a_hi_cnt, 2);
      if (a_busy) a_busy_cnt++;
      else if (a_pbusy) begin
        if (exp_busy.size() == 0) chk("a_busy_extra", a_busy_cnt, 32'hffff_ffff);
        else chk("a_busy_len", a_busy_cnt, exp_busy.pop_front());
        a_busy_cnt = 0;
      end
      if (a_osd) a_osd_cnt++;
      else if (a_posd) begin
        if (exp_osd.size() == 0) chk("a_osd_extra", a_osd_cnt, 32'hffff_ffff);
        else chk("a_osd_len", a_osd_cnt, exp_osd.pop_front());
        a_osd_cnt = 0;
      end
      if (a_rd_en) begin
        if (exp_addr.size() == 0) chk("a_rd_extra", {19'h0, a_rd_addr}, 32'hffff_ffff);
        else chk("a_rd_addr", {19'h0, a_rd_addr}, {19'h0, exp_addr.pop_front()});
      end
      if (a_done) begin
        a_done_cnt++;
        chk("a_done_busy_low", {31'h0, a_busy}, 32'h0);
      end
      a_pstb = a_strobe; a_pbusy = a_busy; a_posd = a_osd;
    end
  end

  // Monitor B
  int b_rd_cnt = 0, b_done_cnt = 0, b_busy_cnt = 0, b_osd_cnt = 0, b_hi_cnt = 0;
  logic b_pstb = 1'b0, b_pbusy = 1'b0, b_posd = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_pstb = 1'b0; b_pbusy = 1'b0; b_posd = 1'b0;
      b_busy_cnt = 0; b_osd_cnt = 0; b_hi_cnt = 0;
    end else begin
      if (b_strobe && !b_pstb) begin
        if (expb_word.size() == 0) chk("b_word_extra", {16'h0, b_din}, 32'hffff_ffff);
        else chk("b_word", {16'h0, b_din}, {16'h0, expb_word.pop_front()});
        b_hi_cnt = 0;
      end
      if (b_strobe) b_hi_cnt++;
      else if (b_pstb) chk("b_strobe_len", b_hi_cnt, 1);
      if (b_busy) b_busy_cnt++;
      else if (b_pbusy) begin
        if (expb_busy.size() == 0) chk("b_busy_extra", b_busy_cnt, 32'hffff_ffff);
        else chk("b_busy_len", b_busy_cnt, expb_busy.pop_front());
        b_busy_cnt = 0;
      end
      if (b_osd) b_osd_cnt++;
      else if (b_posd) begin
        if (expb_osd.size() == 0) chk("b_osd_extra", b_osd_cnt, 32'hffff_ffff);
        else chk("b_osd_len", b_osd_cnt, expb_osd.pop_front());
        b_osd_cnt = 0;
      end
      if (b_rd_en) b_rd_cnt++;
      if (b_done) b_done_cnt++;
      b_pstb = b_strobe; b_pbusy = b_busy; b_posd = b_osd;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_a(input logic [1:0] op);
    @(negedge clk); #1;
    a_op = op; a_req = 1'b1;
    @(negedge clk); #1;
    a_req = 1'b0;
  endtask

  initial begin
    int base;
    bit hit;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    for (int i = 0; i < 6; i++) mem[i] = 8'hA1 + 8'(i);

    // Reset state
    wait_cyc(3); #1;
    chk("rst_busy", {31'h0, a_busy}, 0);
    chk("rst_osd", {31'h0, a_osd}, 0);
    chk("rst_strobe", {31'h0, a_strobe}, 0);
    chk("rst_din", {16'h0, a_din}, 0);
    chk("rst_done", {31'h0, a_done}, 0);
    chk("rst_rd_en", {31'h0, a_rd_en}, 0);
    rst_n = 1'b1;

    // 1: menu enable
    exp_word.push_back(16'h0041); exp_busy.push_back(8); exp_osd.push_back(6); exp_done_a++;
    issue_a(2'd1);
    wait_cyc(14);

    // 2: info box, with ignored req pulses mid-sequence
    a_x = 12'd16; a_y = 12'd32; a_w = 6'd20; a_h = 6'd10; a_rot = 2'd1;
    exp_word.push_back(16'h0045); exp_word.push_back(16'h0010); exp_word.push_back(16'h0020);
    exp_word.push_back(16'h0014); exp_word.push_back(16'h000A); exp_word.push_back(16'h0001);
    exp_busy.push_back(28); exp_osd.push_back(26); exp_done_a++;
    issue_a(2'd2);
    wait_cyc(5);  issue_a(2'd0);
    wait_cyc(7);  issue_a(2'd3);
    wait_cyc(22);

    // 3: bitmap write blk=2 len=4
    a_blk = 5'd2; a_len = 13'd4;
    exp_word.push_back(16'h0022);
    for (int i = 0; i < 4; i++) begin
      exp_word.push_back(16'h00A1 + 16'(i));
      exp_addr.push_back(13'(i));
    end
    exp_busy.push_back(24); exp_osd.push_back(22); exp_done_a++;
    issue_a(2'd3);
    wait_cyc(30);

    // 4: req held through an op1 -> back-to-back sequence from the done cycle
    for (int k = 0; k < 2; k++) begin
      exp_word.push_back(16'h0041); exp_busy.push_back(8); exp_osd.push_back(6);
    end
    exp_done_a += 2;
    @(negedge clk); #1;
    a_op = 2'd1; a_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #1;
      if (a_done) hit = 1'b1;
    end
    chk("t4_done_seen", {31'h0, hit}, 1);
    @(negedge clk); #1;
    chk("t4_restart_busy", {31'h0, a_busy}, 1);
    a_req = 1'b0;
    wait_cyc(14);

    // 5: reset during the 3rd data word of op3
    a_blk = 5'd1; a_len = 13'd6;
    exp_word.push_back(16'h0021);
    for (int i = 0; i < 3; i++) begin
      exp_word.push_back(16'h00A1 + 16'(i));
      exp_addr.push_back(13'(i));
    end
    base = a_rise;
    issue_a(2'd3);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk); #1;
      if (a_rise == base + 4) hit = 1'b1;
    end
    chk("t5_reached_word3", {31'h0, hit}, 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("t5_busy", {31'h0, a_busy}, 0);
    chk("t5_osd", {31'h0, a_osd}, 0);
    chk("t5_strobe", {31'h0, a_strobe}, 0);
    chk("t5_din", {16'h0, a_din}, 0);
    chk("t5_rd_en", {31'h0, a_rd_en}, 0);
    chk("t5_rd_addr", {19'h0, a_rd_addr}, 0);
    chk("t5_done", {31'h0, a_done}, 0);
    rst_n = 1'b1;
    wait_cyc(2);
    exp_word.push_back(16'h0041); exp_busy.push_back(8); exp_osd.push_back(6); exp_done_a++;
    issue_a(2'd1);
    wait_cyc(14);

    // 6: STRW=1 GAPW=3, op3 len=0
    expb_word.push_back(16'h0025); expb_busy.push_back(10); expb_osd.push_back(7);
    @(negedge clk); #1;
    b_op = 2'd3; b_blk = 5'd5; b_len = 13'd0; b_req = 1'b1;
    @(negedge clk); #1;
    b_req = 1'b0;
    wait_cyc(16);

    chk("a_done_count", a_done_cnt, exp_done_a);
    chk("a_words_left", exp_word.size(), 0);
    chk("a_addr_left", exp_addr.size(), 0);
    chk("a_busy_left", exp_busy.size(), 0);
    chk("a_osd_left", exp_osd.size(), 0);
    chk("b_rd_en_count", b_rd_cnt, 0);
    chk("b_done_count", b_done_cnt, 1);
    chk("b_words_left", expb_word.size(), 0);
    chk("b_busy_left", expb_busy.size(), 0);
    chk("b_osd_left", expb_osd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
